// File: rtl/fp_sqrt_iter.sv
// Iterative binary32 square root: one restoring radix-2 root bit per cycle, then GRS rounding.
// Optional build macro FSQRT_SUBNORM_EN normalises subnormal radicands instead of flushing them.
module fp_sqrt_iter #(
  parameter int ITER_BITS = 26
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        flush_i,
  input  logic [31:0] operand_i,
  input  logic [2:0]  rm_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        nv_o,
  output logic        nx_o
);

  localparam int RAD_W = 2 * ITER_BITS;
  localparam int REM_W = ITER_BITS + 2;
  localparam int CNT_W = $clog2(ITER_BITS);
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_ROUND,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [31:0]        r_op;
  logic [2:0]         r_rm;
  logic [RAD_W-1:0]   r_rad;
  logic [REM_W-1:0]   r_rem;
  logic [ITER_BITS-1:0] r_root;
  logic [CNT_W-1:0]   r_cnt;
  logic [7:0]         r_exp;
  logic               r_busy;
  logic               r_done;
  logic [31:0]        r_result;
  logic               r_nv;
  logic               r_nx;

  logic               w_sign;
  logic [7:0]         w_exp;
  logic [22:0]        w_frac;
  logic               w_special;
  logic [31:0]        w_spec_res;
  logic               w_spec_nv;
  logic [23:0]        w_sig;
  logic signed [9:0]  w_e;
  logic signed [9:0]  w_e_res;
  logic [24:0]        w_rad_top;

  assign w_sign = r_op[31];
  assign w_exp  = r_op[30:23];
  assign w_frac = r_op[22:0];

  // Operand classification; everything that does not need iteration resolves here.
  always_comb begin
    w_special  = 1'b1;
    w_spec_res = QNAN;
    w_spec_nv  = 1'b0;
    if (w_exp == 8'hFF) begin
      if (w_frac != 23'd0)
        w_spec_nv = ~w_frac[22];
      else if (w_sign)
        w_spec_nv = 1'b1;
      else
        w_spec_res = POS_INF;
    end else if (w_exp == 8'd0 && w_frac == 23'd0) begin
      w_spec_res = {w_sign, 31'd0};
`ifdef FSQRT_SUBNORM_EN
    end else if (w_sign) begin
      w_spec_nv = 1'b1;
`else
    end else if (w_exp == 8'd0) begin
      w_spec_res = {w_sign, 31'd0};
    end else if (w_sign) begin
      w_spec_nv = 1'b1;
`endif
    end else begin
      w_special = 1'b0;
    end
  end

`ifdef FSQRT_SUBNORM_EN
  logic [4:0] w_lz;
  logic       w_found;

  // Leading zeros of {0, frac}: at least 1 for any nonzero subnormal fraction.
  always_comb begin
    w_lz    = 5'd0;
    w_found = 1'b0;
    for (int i = 22; i >= 0; i--) begin
      if (!w_found && w_frac[i]) begin
        w_lz    = 5'(23 - i);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    if (w_exp == 8'd0) begin
      w_sig = {1'b0, w_frac} << w_lz;
      w_e   = -10'sd126 - $signed({5'd0, w_lz});
    end else begin
      w_sig = {1'b1, w_frac};
      w_e   = $signed({2'b00, w_exp}) - 10'sd127;
    end
  end
`else
  assign w_sig = {1'b1, w_frac};
  assign w_e   = $signed({2'b00, w_exp}) - 10'sd127;
`endif

  // Odd exponent: double the radicand so the halved exponent is exact (floor(e/2) == (e-1)/2).
  assign w_rad_top = w_e[0] ? {w_sig, 1'b0} : {1'b0, w_sig};
  assign w_e_res   = (w_e >>> 1) + 10'sd127;

  logic [REM_W+1:0] w_shift;
  logic [REM_W+1:0] w_trial;
  logic             w_ge;

  assign w_shift = {r_rem, r_rad[RAD_W-1 -: 2]};
  assign w_trial = {2'b00, r_root, 2'b01};
  assign w_ge    = (w_shift >= w_trial);

  logic        w_g;
  logic        w_r;
  logic        w_s;
  logic        w_inc;
  logic [24:0] w_sig_rnd;
  logic [31:0] w_packed;

  assign w_g = r_root[ITER_BITS-25];
  assign w_r = r_root[ITER_BITS-26];
  assign w_s = |r_rem;

  // Root is always positive, so RDN never increments and RMM matches RNE (ties impossible).
  always_comb begin
    w_inc = 1'b0;
    case (r_rm)
      3'b000:  w_inc = w_g;
      3'b011:  w_inc = w_g | w_r | w_s;
      3'b100:  w_inc = w_g;
      default: w_inc = 1'b0;
    endcase
  end

  assign w_sig_rnd = {1'b0, r_root[ITER_BITS-1 -: 24]} + {24'd0, w_inc};
  assign w_packed  = {1'b0,
                      r_exp + {7'd0, w_sig_rnd[24]},
                      w_sig_rnd[23] ? w_sig_rnd[22:0] : 23'd0};

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state  <= S_IDLE;
      r_op     <= 32'd0;
      r_rm     <= 3'd0;
      r_rad    <= '0;
      r_rem    <= '0;
      r_root   <= '0;
      r_cnt    <= '0;
      r_exp    <= 8'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 32'd0;
      r_nv     <= 1'b0;
      r_nx     <= 1'b0;
    end else if (flush_i) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_op    <= operand_i;
            r_rm    <= rm_i;
            r_busy  <= 1'b1;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          if (w_special) begin
            r_result <= w_spec_res;
            r_nv     <= w_spec_nv;
            r_nx     <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_rad   <= {w_rad_top, (RAD_W-25)'(0)};
            r_rem   <= '0;
            r_root  <= '0;
            r_cnt   <= CNT_W'(ITER_BITS - 1);
            r_exp   <= 8'(w_e_res);
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          r_rad  <= {r_rad[RAD_W-3:0], 2'b00};
          r_rem  <= w_ge ? REM_W'(w_shift - w_trial) : REM_W'(w_shift);
          r_root <= {r_root[ITER_BITS-2:0], w_ge};
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == '0)
            r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_result <= w_packed;
          r_nv     <= 1'b0;
          r_nx     <= w_g | w_r | w_s;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign result_o = r_result;
  assign nv_o     = r_nv;
  assign nx_o     = r_nx;

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// Scoreboard bench for fp_sqrt_iter: directed radicands with hand-computed roots, flags and latency.
// Subnormal expectations follow the FSQRT_SUBNORM_EN build macro.
module tb_fp_sqrt_iter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic        flush_i;
  logic [31:0] operand_i;
  logic [2:0]  rm_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        nv_o;
  logic        nx_o;

  fp_sqrt_iter dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .start_i   (start_i),
    .flush_i   (flush_i),
    .operand_i (operand_i),
    .rm_i      (rm_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .result_o  (result_o),
    .nv_o      (nv_o),
    .nx_o      (nx_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] op;
    logic [31:0] res;
    logic        nv;
    logic        nx;
    int          due;
  } exp_t;

  typedef struct {
    logic [31:0] op;
    logic [2:0]  rm;
    logic [31:0] res;
    logic        nv;
    logic        nx;
    logic        spec;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  exp_t mon_e;
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (reset_i === 1'b1 && done_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done_o=1 result=%h at cycle %0d want no done", result_o, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("result", result_o, mon_e.res);
        chk("nv", {31'd0, nv_o}, {31'd0, mon_e.nv});
        chk("nx", {31'd0, nx_o}, {31'd0, mon_e.nx});
        chk("done_cycle", cyc, mon_e.due);
        chk("busy_at_done", {31'd0, busy_o}, 32'd1);
        $display("txn op=%h result=%h nv=%b nx=%b cycle=%0d", mon_e.op, result_o, nv_o, nx_o, cyc);
      end
    end
  end

  // Drives start_i for the current cycle; caller is positioned at a negedge.
  task automatic start_op(input logic [31:0] op, input logic [2:0] rm, output int n);
    operand_i = op;
    rm_i      = rm;
    start_i   = 1'b1;
    n         = cyc;
    @(negedge clk_i);
    start_i   = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] op, input logic [31:0] res, input logic nv,
                          input logic nx, input int due);
    exp_t e;
    e.op = op; e.res = res; e.nv = nv; e.nx = nx; e.due = due;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(posedge clk_i);
      t++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending want 0 after %0d cycles", sb.size(), t);
      sb.delete();
    end
  endtask

  task automatic run(input vec_t v);
    int n;
    @(negedge clk_i);
    start_op(v.op, v.rm, n);
    push_exp(v.op, v.res, v.nv, v.nx, n + (v.spec ? 2 : 29));
    wait_drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish by 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_i = 1'b0; start_i = 1'b0; flush_i = 1'b0; operand_i = 32'd0; rm_i = 3'd0;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_nv", {31'd0, nv_o}, 32'd0);
    chk("rst_nx", {31'd0, nx_o}, 32'd0);
    reset_i = 1'b1;
    @(negedge clk_i);

    // sqrt(4.0) with busy window checks.
    chk("busy_before", {31'd0, busy_o}, 32'd0);
    start_op(32'h4080_0000, 3'd0, n);
    push_exp(32'h4080_0000, 32'h4000_0000, 1'b0, 1'b0, n + 29);
    chk("busy_n1", {31'd0, busy_o}, 32'd1);
    chk("done_n1", {31'd0, done_o}, 32'd0);
    repeat (28) @(negedge clk_i);
    chk("busy_n29", {31'd0, busy_o}, 32'd1);
    chk("done_n29", {31'd0, done_o}, 32'd1);
    @(negedge clk_i);
    chk("busy_n30", {31'd0, busy_o}, 32'd0);
    chk("done_n30", {31'd0, done_o}, 32'd0);
    wait_drain();

    vecs.push_back('{32'h4000_0000, 3'd0, 32'h3FB5_04F3, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{32'h4000_0000, 3'd3, 32'h3FB5_04F4, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{32'h4000_0000, 3'd1, 32'h3FB5_04F3, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{32'h4000_0000, 3'd7, 32'h3FB5_04F3, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{32'h4000_0000, 3'd2, 32'h3FB5_04F3, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{32'h4000_0000, 3'd4, 32'h3FB5_04F3, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{32'h3F80_0000, 3'd3, 32'h3F80_0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h3E80_0000, 3'd0, 32'h3F00_0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h4110_0000, 3'd0, 32'h4040_0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'hBF80_0000, 3'd0, 32'h7FC0_0000, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{32'h7F80_0001, 3'd0, 32'h7FC0_0000, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{32'h7FC0_0000, 3'd0, 32'h7FC0_0000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{32'hFF80_0000, 3'd0, 32'h7FC0_0000, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{32'h8000_0000, 3'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{32'h0000_0000, 3'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{32'h7F80_0000, 3'd0, 32'h7F80_0000, 1'b0, 1'b0, 1'b1});
`ifdef FSQRT_SUBNORM_EN
    vecs.push_back('{32'h0000_0001, 3'd0, 32'h1A35_04F3, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{32'h8000_0001, 3'd0, 32'h7FC0_0000, 1'b1, 1'b0, 1'b1});
`else
    vecs.push_back('{32'h0000_0001, 3'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{32'h8000_0001, 3'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b1});
`endif
    foreach (vecs[i]) run(vecs[i]);

    // A start pulse while busy must be ignored.
    @(negedge clk_i);
    start_op(32'h4080_0000, 3'd0, n);
    push_exp(32'h4080_0000, 32'h4000_0000, 1'b0, 1'b0, n + 29);
    repeat (4) @(negedge clk_i);
    operand_i = 32'h4110_0000;
    start_i   = 1'b1;
    @(negedge clk_i);
    start_i   = 1'b0;
    wait_drain();

    // Flush mid-iteration: no done, idle next cycle, immediate restart.
    @(negedge clk_i);
    start_op(32'h4080_0000, 3'd0, n);
    repeat (9) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    chk("flush_busy", {31'd0, busy_o}, 32'd0);
    chk("flush_done", {31'd0, done_o}, 32'd0);
    start_op(32'h4110_0000, 3'd0, n);
    push_exp(32'h4110_0000, 32'h4040_0000, 1'b0, 1'b0, n + 29);
    wait_drain();

    // Asynchronous reset mid-iteration.
    @(negedge clk_i);
    start_op(32'h4000_0000, 3'd3, n);
    repeat (14) @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy_o}, 32'd0);
    chk("arst_done", {31'd0, done_o}, 32'd0);
    chk("arst_result", result_o, 32'd0);
    chk("arst_nv", {31'd0, nv_o}, 32'd0);
    chk("arst_nx", {31'd0, nx_o}, 32'd0);
    @(negedge clk_i);
    reset_i = 1'b1;
    run('{32'h4110_0000, 3'd0, 32'h4040_0000, 1'b0, 1'b0, 1'b0});

    repeat (40) @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_sqrt_iter.md
Name: fp_sqrt_iter

Overview:
Iterative single-precision (binary32) square-root unit. It produces the root mantissa one bit per cycle, and derives the guard/round/sticky bits from the partial root and final remainder. It then applies the RISC-V rounding modes internally. It sits in the FPU arithmetic cluster beside the other multi-cycle units and is driven by the FPU issue logic with a start/done handshake.

Parameters:
ITER_BITS, 26, root bits generated: 24 mantissa bits (including the hidden bit) plus G and R.

Ports:
clk_i  input  1  clock, all state on rising edge
reset_i  input  1  asynchronous active-low reset
start_i  input  1  operation request; sampled only in IDLE
flush_i  input  1  synchronous abort; returns to IDLE next cycle, no done_o
operand_i  input  32  binary32 radicand; captured on an accepted start
rm_i  input  3  rounding mode, encoded as in frm; captured on an accepted start
busy_o  output  1  high from the cycle after accept until the DONE cycle inclusive
done_o  output  1  one-cycle pulse; result_o and the flags are valid in this cycle
result_o  output  32  binary32 root; held until the next accept
nv_o  output  1  invalid flag
nx_o  output  1  inexact flag

Behaviour:
- Reset (async, reset_i=0):
  - State goes to IDLE.
  - busy_o=0, done_o=0, result_o=32'h0, nv_o=0, nx_o=0.
  - Any in-flight operation is discarded.
- States and transitions:
  - IDLE -> PREP: start_i=1. Operand and rm are latched. Accept cycle = N.
  - PREP (N+1): classify the operand.
    - Special -> DONE.
    - Otherwise unpack and go to ITER.
  - ITER (N+2..N+27): 26 cycles, one restoring radix-2 root bit per cycle; a counter runs 25 down to 0.
  - ROUND (N+28): compute sticky S = (remainder != 0), apply rounding, pack the result.
  - DONE (N+29 for the normal path; N+2 for specials): done_o=1 for one cycle, then IDLE.
- start_i outside IDLE is ignored. A new start may be accepted in the cycle after DONE.
- flush_i has priority over every transition.
- Special cases (resolved in PREP):
  - NaN (sNaN or qNaN) -> 32'h7FC00000; nv_o = 1 only for sNaN.
  - Negative nonzero operand, including -inf -> 32'h7FC00000, nv_o=1.
  - +0 -> 32'h00000000; -0 -> 32'h80000000.
  - +inf -> 32'h7F800000.
  - All specials have nx_o=0.
- Normal path:
  - Unbiased exponent e = exp-127.
  - If e is odd, shift the significand 1.m left by 1 and use e-1.
  - Radicand lies in [1,4); root lies in [1,2).
  - Result exponent = (e>>>1)+127.
- Rounding on {G,R,S}, result sign always 0:
  - 000 RNE: increment if G. Exact ties cannot occur.
  - 001 RTZ: never increment.
  - 010 RDN: never increment (result is positive).
  - 011 RUP: increment if any of G,R,S.
  - 100 RMM: increment if G.
  - 101/110/111: treated as RTZ.
- Rounding arithmetic:
  - Increment is applied to the 24-bit significand.
  - Carry-out renormalises the significand to 1.0 and increments the exponent.
  - Overflow to inf is impossible.
- nx_o = G|R|S on the normal path.
- Remainder register is ITER_BITS+2 bits wide and the partial root register is ITER_BITS bits wide. Neither may truncate.

Optional Feature:
FSQRT_SUBNORM_EN
- Defined: in PREP, a subnormal operand is normalised with a leading-zero count (one cycle, same timing) to exponent -126-lz. It then proceeds on the normal path. The result is always normal.
- Undefined: subnormal operands are flushed to a signed zero in PREP.
  - +subnormal -> 32'h00000000.
  - -subnormal -> 32'h80000000.
  - Both take the special timing (done at N+2), with nv_o=0 and nx_o=0.

Test Plan:
1. operand 32'h40800000 (4.0), rm=000, start at cycle N -> done_o at N+29, result 32'h40000000, nx_o=0, nv_o=0, busy_o high N+1..N+29.
2. operand 32'h40000000 (2.0):
   - rm=000 -> 32'h3FB504F3, nx_o=1.
   - rm=011 -> 32'h3FB504F4, nx_o=1.
   - rm=001 and rm=111 -> 32'h3FB504F3.
3. Specials, each with done_o at N+2:
   - 32'hBF800000 -> 32'h7FC00000, nv_o=1.
   - 32'h7F800001 -> 32'h7FC00000, nv_o=1.
   - 32'h80000000 -> 32'h80000000, nv_o=0.
   - 32'h7F800000 -> 32'h7F800000.
4. operand 32'h00000001, rm=000:
   - With FSQRT_SUBNORM_EN -> 32'h1A3504F3, nx_o=1, done at N+29.
   - Without -> 32'h00000000 at N+2.
5. Start 4.0, then:
   - pulse start_i with 9.0 at N+5 -> ignored, result 32'h40000000.
   - assert flush_i at N+10 -> no done_o, IDLE at N+11, next start accepted.
6. Drop reset_i at N+15 mid-ITER -> outputs clear immediately. After release, sqrt(32'h41100000) (9.0) completes with 32'h40400000.
